// File: rtl/orb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : orb_pkg
// Brief    : Shared widths, sideband kind codes and EOF window defaults for
//            the ORB sideband scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package orb_pkg;

    localparam int c_coord_w = 10;
    localparam int c_match_w = 4 * c_coord_w;
    localparam int c_side_w  = 2 * c_coord_w;

    localparam int c_eof_h_default = 718;
    localparam int c_eof_v_default = 479;

    localparam logic [1:0] KIND_IDLE = 2'b00;
    localparam logic [1:0] KIND_H1   = 2'b01;
    localparam logic [1:0] KIND_H2   = 2'b10;
    localparam logic [1:0] KIND_CYC  = 2'b11;

    // Sideband beats carry x in the upper half and y in the lower half.
    function automatic logic [c_side_w-1:0] pack_xy(
        input logic [c_coord_w-1:0] x,
        input logic [c_coord_w-1:0] y
    );
        return {x, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/orb_match_fifo.sv
`default_nettype none
// ============================================================================
// Module   : orb_match_fifo
// Brief    : Show-ahead synchronous FIFO holding ORB match words.
// Revision : 1.0 - initial release
// ============================================================================
module orb_match_fifo #(
    parameter int WIDTH   = 40,
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int                 c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw-1:0]    c_ptr_one = c_aw'(1);
    localparam logic [LEVEL_W-1:0] c_depth   = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] c_cnt_one = LEVEL_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [LEVEL_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign level = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/orb_sideband_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : orb_sideband_scheduler
// Brief    : Arbitrates the 20-bit output sideband between buffered match
//            pairs and the end-of-frame cycle report; owns the frame timer.
// Revision : 1.0 - initial release
// ============================================================================
module orb_sideband_scheduler
    import orb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CYC_BIAS   = 3,
    parameter int EOF_H      = c_eof_h_default,
    parameter int EOF_V      = c_eof_v_default
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic        pix_en,
    input  logic        match_valid,
    input  logic [39:0] match_xy,
    input  logic [6:0]  frame_id,
    input  logic [9:0]  hs_cnt,
    input  logic [9:0]  vs_cnt,
    input  logic        beat_en,
    output logic [19:0] side_data,
    output logic [1:0]  side_kind,
    output logic        fps_en,
    output logic [19:0] cycle_per_frame,
    output logic [4:0]  fifo_level,
    output logic [7:0]  drop_cnt
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_h1    = 2'd1;
    localparam logic [1:0]  c_st_h2    = 2'd2;
    localparam logic [1:0]  c_st_eofr  = 2'd3;
    localparam logic [9:0]  c_eof_h    = 10'(EOF_H);
    localparam logic [9:0]  c_eof_v    = 10'(EOF_V);
    localparam logic [19:0] c_cyc_bias = 20'(CYC_BIAS);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_match_w-1:0] r_hold;
    logic                 r_eof_req;
    logic                 r_win_prev;
    logic [6:0]           r_frame_id;
    logic                 r_fps_en;
    logic [19:0]          r_cyc_cnt;
    logic [19:0]          r_cycle_per_frame;
    logic [7:0]           r_drop_cnt;

    logic                 w_win;
    logic                 w_eof_edge;
    logic                 w_frame_chg;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_eof_clr;
    logic                 w_drop;
    logic [c_match_w-1:0] w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [4:0]           w_fifo_level;

    assign w_win       = (hs_cnt >= c_eof_h) && (vs_cnt == c_eof_v);
    assign w_eof_edge  = w_win & ~r_win_prev;
    assign w_frame_chg = (frame_id != r_frame_id);
    assign w_push_req  = pix_en & match_valid;
    assign w_drop      = w_push_req & w_fifo_full & ~w_pop;

    orb_match_fifo #(
        .WIDTH   (c_match_w),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (5)
    ) u_fifo (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (match_xy),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    // Frame timer: a new frame id restarts counting even on an EOF edge.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_win_prev        <= 1'b0;
            r_frame_id        <= '0;
            r_fps_en          <= 1'b0;
            r_cyc_cnt         <= '0;
            r_cycle_per_frame <= '0;
        end else begin
            r_win_prev <= w_win;
            if (w_frame_chg) begin
                r_frame_id <= frame_id;
                r_fps_en   <= 1'b1;
                r_cyc_cnt  <= '0;
            end else begin
                if (r_fps_en && pix_en) begin
                    r_cyc_cnt <= r_cyc_cnt + 20'd1;
                end
                if (w_eof_edge) begin
                    r_fps_en <= 1'b0;
                end
            end
            if (w_eof_edge) begin
                r_cycle_per_frame <= r_cyc_cnt + c_cyc_bias;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_eof_req <= 1'b0;
        end else if (w_eof_edge) begin
            r_eof_req <= 1'b1;
        end else if (w_eof_clr) begin
            r_eof_req <= 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // EOF report only wins between pairs; H1 always runs on into H2.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_eof_clr   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_eof_req) begin
                    w_state_nxt = c_st_eofr;
                end else if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_st_h1;
                end
            end
            c_st_h1: begin
                if (beat_en) begin
                    w_state_nxt = c_st_h2;
                end
            end
            c_st_h2: begin
                if (beat_en) begin
                    if (r_eof_req) begin
                        w_state_nxt = c_st_eofr;
                    end else if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_st_h1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_eofr: begin
                if (beat_en) begin
                    w_eof_clr   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state <= c_st_idle;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_hold <= w_fifo_dout;
            end
        end
    end

    always_comb begin
        side_data = '0;
        side_kind = KIND_IDLE;
        case (r_state)
            c_st_h1: begin
                side_data = pack_xy(r_hold[9:0], r_hold[19:10]);
                side_kind = KIND_H1;
            end
            c_st_h2: begin
                side_data = pack_xy(r_hold[29:20], r_hold[39:30]);
                side_kind = KIND_H2;
            end
            c_st_eofr: begin
                side_data = r_cycle_per_frame;
                side_kind = KIND_CYC;
            end
            default: begin
                side_data = '0;
                side_kind = KIND_IDLE;
            end
        endcase
    end

    assign fps_en          = r_fps_en;
    assign cycle_per_frame = r_cycle_per_frame;
    assign fifo_level      = w_fifo_level;
    assign drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_orb_sideband_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_orb_sideband_scheduler
// Brief    : Self-checking bench for orb_sideband_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_orb_sideband_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        match_valid = 1'b0;
    logic [39:0] match_xy = '0;
    logic [6:0]  frame_id = '0;
    logic [9:0]  hs_cnt = '0;
    logic [9:0]  vs_cnt = '0;
    logic        beat_en = 1'b0;
    logic [19:0] side_data;
    logic [1:0]  side_kind;
    logic        fps_en;
    logic [19:0] cycle_per_frame;
    logic [4:0]  fifo_level;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] ent [10];
    logic [39:0] extra_m;

    always #5 clk = ~clk;

    orb_sideband_scheduler #(
        .FIFO_DEPTH (8),
        .CYC_BIAS   (3),
        .EOF_H      (718),
        .EOF_V      (479)
    ) u_dut (
        .s_axis_aclk     (clk),
        .s_axis_aresetn  (rst_n),
        .pix_en          (pix_en),
        .match_valid     (match_valid),
        .match_xy        (match_xy),
        .frame_id        (frame_id),
        .hs_cnt          (hs_cnt),
        .vs_cnt          (vs_cnt),
        .beat_en         (beat_en),
        .side_data       (side_data),
        .side_kind       (side_kind),
        .fps_en          (fps_en),
        .cycle_per_frame (cycle_per_frame),
        .fifo_level      (fifo_level),
        .drop_cnt        (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pix_en      = 1'b0;
        match_valid = 1'b0;
        beat_en     = 1'b0;
        hs_cnt      = '0;
        vs_cnt      = '0;
    endtask

    function automatic logic [39:0] rand_match();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    // Expected slot words {kind, data}: first beat {x1,y1}, second {x2,y2}.
    function automatic logic [21:0] slot_h1(input logic [39:0] m);
        return {2'b01, m[9:0], m[19:10]};
    endfunction

    function automatic logic [21:0] slot_h2(input logic [39:0] m);
        return {2'b10, m[29:20], m[39:30]};
    endfunction

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({side_kind, side_data, fps_en, cycle_per_frame, fifo_level, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: kind=%0d data=%h fps=%b cpf=%0d lvl=%0d drop=%0d, required all zero",
                     side_kind, side_data, fps_en, cycle_per_frame, fifo_level, drop_cnt);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            pix_en = 1'b1; match_valid = 1'b1; match_xy = rand_match();
            tick();
        end
        quiet();
        beat_en = 1'b1;
        tick();
        beat_en = 1'b0;
        n_cmp++;
        if (side_kind !== 2'b10 || fifo_level !== 5'd3) begin
            n_err++;
            $display("FAIL reset_setup: kind=%0d lvl=%0d, required kind=2 lvl=3", side_kind, fifo_level);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({side_kind, side_data, fps_en, cycle_per_frame, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_async: kind=%0d data=%h fps=%b cpf=%0d drop=%0d, required all zero",
                     side_kind, side_data, fps_en, cycle_per_frame, drop_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (fifo_level !== 5'd0 || side_kind !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: lvl=%0d kind=%0d, required lvl=0 kind=0", fifo_level, side_kind);
        end
    endtask

    task automatic test_single_match();
        logic [39:0] m;
        for (int it = 0; it < 3; it++) begin
            m = (it == 0) ? {10'd4, 10'd3, 10'd2, 10'd1} : rand_match();
            beat_en = 1'b1; pix_en = 1'b1; match_valid = 1'b1; match_xy = m;
            tick();
            pix_en = 1'b0; match_valid = 1'b0;
            n_cmp++;
            if (side_kind !== 2'b00) begin
                n_err++;
                $display("FAIL single_lat0: kind=%0d, required 0", side_kind);
            end
            tick();
            n_cmp++;
            if ({side_kind, side_data} !== slot_h1(m)) begin
                n_err++;
                $display("FAIL single_h1: got %h, required %h", {side_kind, side_data}, slot_h1(m));
            end
            tick();
            n_cmp++;
            if ({side_kind, side_data} !== slot_h2(m)) begin
                n_err++;
                $display("FAIL single_h2: got %h, required %h", {side_kind, side_data}, slot_h2(m));
            end
            tick();
            n_cmp++;
            if ({side_kind, side_data} !== 22'd0) begin
                n_err++;
                $display("FAIL single_idle: got %h, required 0", {side_kind, side_data});
            end
            beat_en = 1'b0;
        end
    endtask

    task automatic test_frame_timer();
        int n_pix;
        int len;
        logic [19:0] exp_cpf;
        for (int it = 0; it < 3; it++) begin
            quiet();
            frame_id = frame_id + 7'd1;
            tick();
            n_cmp++;
            if (fps_en !== 1'b1) begin
                n_err++;
                $display("FAIL timer_start: fps_en=%b, required 1", fps_en);
            end
            len = (it == 0) ? 1000 : int'($urandom_range(400, 50));
            n_pix = 0;
            for (int c = 0; c < len; c++) begin
                pix_en = (it == 0) ? 1'b1 : (($urandom & 3) != 0);
                if (pix_en) n_pix++;
                tick();
            end
            pix_en = 1'b0;
            hs_cnt = (it == 0) ? 10'd718 : 10'($urandom_range(1023, 718));
            vs_cnt = 10'd479;
            tick();
            exp_cpf = 20'(n_pix + 3);
            n_cmp++;
            if (cycle_per_frame !== exp_cpf || fps_en !== 1'b0) begin
                n_err++;
                $display("FAIL timer_latch: cpf=%0d fps=%b, required cpf=%0d fps=0",
                         cycle_per_frame, fps_en, exp_cpf);
            end
            hs_cnt = '0; vs_cnt = '0;
            tick();
            n_cmp++;
            if ({side_kind, side_data} !== {2'b11, exp_cpf}) begin
                n_err++;
                $display("FAIL timer_report: got %h, required %h", {side_kind, side_data}, {2'b11, exp_cpf});
            end
            beat_en = 1'b1;
            tick();
            beat_en = 1'b0;
            n_cmp++;
            if (side_kind !== 2'b00) begin
                n_err++;
                $display("FAIL timer_done: kind=%0d, required 0", side_kind);
            end
        end
    endtask

    task automatic test_eof_during_pair();
        logic [39:0] a;
        logic [39:0] b;
        logic [21:0] exp_q[$];
        logic [21:0] got_q[$];
        a = rand_match();
        b = rand_match();
        quiet();
        frame_id = frame_id + 7'd1;
        tick();
        pix_en = 1'b1; match_valid = 1'b1; match_xy = a;
        tick();
        match_xy = b;
        tick();
        quiet();
        n_cmp++;
        if ({side_kind, side_data} !== slot_h1(a)) begin
            n_err++;
            $display("FAIL eofpair_h1: got %h, required %h", {side_kind, side_data}, slot_h1(a));
        end
        hs_cnt = 10'd718; vs_cnt = 10'd479;
        tick();
        hs_cnt = '0; vs_cnt = '0;
        exp_q = '{slot_h1(a), slot_h2(a), {2'b11, 20'd5}, slot_h1(b), slot_h2(b)};
        beat_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (side_kind !== 2'b00) got_q.push_back({side_kind, side_data});
            tick();
        end
        beat_en = 1'b0;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL eofpair_count: got %0d slots, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL eofpair_slot%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        quiet();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            ent[i] = rand_match();
            pix_en = 1'b1; match_valid = 1'b1; match_xy = ent[i];
            tick();
        end
        quiet();
        n_cmp++;
        if (fifo_level !== 5'd8 || drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL overflow: lvl=%0d drop=%0d, required lvl=8 drop=1", fifo_level, drop_cnt);
        end
        n_cmp++;
        if ({side_kind, side_data} !== slot_h1(ent[0])) begin
            n_err++;
            $display("FAIL overflow_head: got %h, required %h", {side_kind, side_data}, slot_h1(ent[0]));
        end
    endtask

    task automatic test_push_pop_full();
        extra_m = rand_match();
        beat_en = 1'b1;
        tick();
        n_cmp++;
        if ({side_kind, side_data} !== slot_h2(ent[0]) || fifo_level !== 5'd8) begin
            n_err++;
            $display("FAIL pushpop_pre: got %h lvl=%0d, required %h lvl=8",
                     {side_kind, side_data}, fifo_level, slot_h2(ent[0]));
        end
        pix_en = 1'b1; match_valid = 1'b1; match_xy = extra_m;
        tick();
        quiet();
        n_cmp++;
        if (fifo_level !== 5'd8 || drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL pushpop_full: lvl=%0d drop=%0d, required lvl=8 drop=1", fifo_level, drop_cnt);
        end
        n_cmp++;
        if ({side_kind, side_data} !== slot_h1(ent[1])) begin
            n_err++;
            $display("FAIL pushpop_next: got %h, required %h", {side_kind, side_data}, slot_h1(ent[1]));
        end
    endtask

    task automatic test_drop_saturation();
        logic [21:0] exp_q[$];
        logic [21:0] got_q[$];
        for (int i = 0; i < 100; i++) begin
            pix_en = 1'b1; match_valid = 1'b1; match_xy = rand_match();
            tick();
        end
        n_cmp++;
        if (drop_cnt !== 8'd101) begin
            n_err++;
            $display("FAIL drop_count: drop=%0d, required 101", drop_cnt);
        end
        for (int i = 0; i < 160; i++) begin
            pix_en = 1'b1; match_valid = 1'b1; match_xy = rand_match();
            tick();
        end
        quiet();
        n_cmp++;
        if (drop_cnt !== 8'd255 || fifo_level !== 5'd8) begin
            n_err++;
            $display("FAIL drop_saturate: drop=%0d lvl=%0d, required drop=255 lvl=8", drop_cnt, fifo_level);
        end
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(slot_h1(ent[i]));
            exp_q.push_back(slot_h2(ent[i]));
        end
        exp_q.push_back(slot_h1(extra_m));
        exp_q.push_back(slot_h2(extra_m));
        beat_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (side_kind !== 2'b00) got_q.push_back({side_kind, side_data});
            tick();
        end
        beat_en = 1'b0;
        n_cmp++;
        if (got_q.size() != exp_q.size() || fifo_level !== 5'd0) begin
            n_err++;
            $display("FAIL drain_count: got %0d slots lvl=%0d, required %0d slots lvl=0",
                     got_q.size(), fifo_level, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL drain_slot%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [21:0] exp_q[$];
        logic [21:0] got_q[$];
        logic [39:0] m;
        int acc;
        int done;
        int sel;
        acc = 0;
        done = 0;
        quiet();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 800; c++) begin
            beat_en = ($urandom_range(0, 2) != 0);
            if (beat_en && side_kind !== 2'b00) begin
                got_q.push_back({side_kind, side_data});
                if (side_kind === 2'b10) done++;
            end
            m = rand_match();
            match_xy = m;
            sel = int'($urandom_range(0, 3));
            pix_en = (sel == 1 || sel == 3);
            match_valid = (sel == 2 || sel == 3);
            if (sel == 3) begin
                if (acc - done < 8) begin
                    acc++;
                    exp_q.push_back(slot_h1(m));
                    exp_q.push_back(slot_h2(m));
                end else begin
                    match_valid = 1'b0;
                end
            end
            tick();
        end
        quiet();
        beat_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (side_kind !== 2'b00) got_q.push_back({side_kind, side_data});
            tick();
        end
        beat_en = 1'b0;
        n_cmp++;
        if (got_q.size() != exp_q.size() || drop_cnt !== 8'd0 || fifo_level !== 5'd0) begin
            n_err++;
            $display("FAIL random_totals: slots=%0d drop=%0d lvl=%0d, required slots=%0d drop=0 lvl=0",
                     got_q.size(), drop_cnt, fifo_level, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL random_slot%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_frame_timer();
        test_eof_during_pair();
        test_overflow();
        test_push_pop_full();
        test_drop_saturation();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
